sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Sequencer for the SHA-256 compression datapath. It buffers one 512-bit message block and starts the compression core. It then serves the core one schedule word W_t per round, paced by the core's start-new (STN) strobe. When the core finishes, it latches the 256-bit digest. Message expansion uses a 16-entry circular word buffer and one shared 32-bit adder, computing each W_16..W_63 in the slack between rounds.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- blk_wr_en  in  1  write one block word; honoured only in IDLE
- blk_wr_addr  in  4  word index; 0 = most-significant word of the block
- blk_wr_data  in  32  block word
- go  in  1  start hashing the buffered block; honoured only in IDLE
- comp_start  out  1  one-cycle start pulse to the compression core
- comp_wt  out  32  current schedule word W_t to the core; registered
- comp_stn  in  1  core strobe; high for the 4 cycles of round t from its Wt-consume cycle
- comp_done  in  1  core completion pulse
- comp_digest  in  256  core digest, {H7..H0}
- digest_out  out  256  latched digest
- busy  out  1  high from go accept until done
- done  out  1  one-cycle pulse; digest_out valid
- err  out  1  sticky protocol error (see Configuration)

## Operation
- States: IDLE, START, WAIT_RISE, FETCH, E1, E2, E3, E4, WAIT_DONE, DONE.
- IDLE: a write with blk_wr_en stores buf[blk_wr_addr] = blk_wr_data. A write coinciding with go is stored before W0 is read. go -> START.
- START: comp_start=1, comp_wt<=buf[0], rnd<=0, busy<=1 -> WAIT_RISE.
- Rise detect: stn_q<=comp_stn; rise = comp_stn & ~stn_q.
- WAIT_RISE, on rise:
  - rnd==63 -> WAIT_DONE.
  - Else j=rnd+1, rnd<=j.
  - j<16 -> FETCH.
  - j>=16 -> E1.
- FETCH: comp_wt<=buf[j] -> WAIT_RISE.
- Expansion computes W_j = σ1(W_j-2) + W_j-7 + σ0(W_j-15) + W_j-16, mod 2^32:
  - E1: acc = σ1(buf[(j+14)&15]).
  - E2: acc += buf[(j+9)&15].
  - E3: acc += σ0(buf[(j+1)&15]).
  - E4: sum = acc + buf[j&15]; buf[j&15]<=sum, comp_wt<=sum -> WAIT_RISE.
- Sigma functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- WAIT_DONE, on comp_done: digest_out<=comp_digest -> DONE.
- DONE: done=1, busy<=0 -> IDLE.
- go and blk_wr_en outside IDLE: ignored. The buffer is overwritten by expansion, so a new block must be fully rewritten before the next go.
- Reset, including mid-operation: state IDLE; rnd=0; acc=0; buf cleared.
- Output reset values: comp_start=0, comp_wt=0, digest_out=0, busy=0, done=0, err=0.

## Timing
- go sampled in cycle 0 -> comp_start high and comp_wt=W0 in cycle 1.
- Core consumes W0 in cycle 6, when comp_stn first goes high.
- comp_wt changes only in the cycle after a rise is detected (FETCH path) or after E4. It is stable through every core consume cycle.
- W_t latency after the rise of round t-1:
  - t<16: 2 cycles (rise, FETCH).
  - t>=16: 5 cycles (rise, E1..E4).
  - Budget is 8 cycles (core round length).
- comp_done in cycle N -> digest_out updated and done high in cycle N+1; busy low from N+2.
- comp_done arriving in any state other than WAIT_DONE is ignored. In that case err sets when the checker is compiled in.

## Configuration
- SHA256_ROUND_CTRL_ERR_EN defined: err is set sticky, and cleared only by reset, on any of:
  - a rise while in E1..E4 or FETCH;
  - a rise in WAIT_DONE (65th round);
  - comp_done outside WAIT_DONE.
- Each of these events leaves the FSM's normal transitions unchanged.
- Not defined: err tied 0 and no checker logic is synthesised.

## Test plan
- Load block "abc" (0x61626380, words 1..14 = 0, word 15 = 0x00000018), go, with a model core -> done once. digest_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad in {H0..H7} order.
- Same block, check comp_wt at each stn rise:
  - round 0 = 0x61626380;
  - round 15 = 0x00000018;
  - round 16 = 0x61626380;
  - round 17 = 0x000F0000.
- go while busy at round 20, and blk_wr_en mid-run -> no effect; the digest is unchanged from the first test.
- rst_n low at round 30 -> all outputs 0 next cycle. Reload and re-run "abc" -> correct digest.
- ERR_EN: inject an extra stn rise in E2 -> err=1 and stays 1. Without the macro, err stays 0.
- Write on the same cycle as go to word 0 = 0xFFFFFFFF -> comp_wt=0xFFFFFFFF in cycle 1.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: buffers one block, paces W_t to the core, expands W_16..W_63
// in place with one adder and latches the digest. Define SHA256_ROUND_CTRL_ERR_EN for err.
module sha256_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_wr_en,
    input  logic [3:0]   blk_wr_addr,
    input  logic [31:0]  blk_wr_data,
    input  logic         go,
    output logic         comp_start,
    output logic [31:0]  comp_wt,
    input  logic         comp_stn,
    input  logic         comp_done,
    input  logic [255:0] comp_digest,
    output logic [255:0] digest_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [3:0] {
        StIdle, StStart, StWaitRise, StFetch, StE1, StE2, StE3, StE4, StWaitDone, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   wbuf_q [16];
    logic [5:0]    rnd_q, rnd_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   comp_wt_q, comp_wt_d;
    logic          comp_start_q, comp_start_d;
    logic [255:0]  digest_q, digest_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          stn_q;
    logic          rise;

    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [31:0]   wr_data;

    logic [3:0]    j;
    logic [3:0]    idx_m2, idx_m7, idx_m15;
    logic [31:0]   add_a, add_b, sum;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign rise = comp_stn & ~stn_q;

    // Slot j&15 holds W_j-16 until E4 overwrites it with W_j.
    assign j       = rnd_q[3:0];
    assign idx_m2  = j + 4'd14;
    assign idx_m7  = j + 4'd9;
    assign idx_m15 = j + 4'd1;

    always_comb begin
        add_a = (state_q == StE1) ? 32'd0 : acc_q;
        case (state_q)
            StE1:    add_b = sig1(wbuf_q[idx_m2]);
            StE2:    add_b = wbuf_q[idx_m7];
            StE3:    add_b = sig0(wbuf_q[idx_m15]);
            StE4:    add_b = wbuf_q[j];
            default: add_b = 32'd0;
        endcase
        sum = add_a + add_b;
    end

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        acc_d        = acc_q;
        comp_wt_d    = comp_wt_q;
        comp_start_d = 1'b0;
        digest_d     = digest_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = 4'd0;
        wr_data      = 32'd0;

        case (state_q)
            StIdle: begin
                if (blk_wr_en) begin
                    wr_en   = 1'b1;
                    wr_idx  = blk_wr_addr;
                    wr_data = blk_wr_data;
                end
                // W0 is loaded at go acceptance so the core sees it alongside comp_start.
                if (go) begin
                    state_d      = StStart;
                    comp_start_d = 1'b1;
                    busy_d       = 1'b1;
                    rnd_d        = 6'd0;
                    comp_wt_d    = (blk_wr_en && blk_wr_addr == 4'd0) ? blk_wr_data : wbuf_q[0];
                end
            end
            StStart: state_d = StWaitRise;
            StWaitRise: begin
                if (rise) begin
                    if (rnd_q == 6'd63) begin
                        state_d = StWaitDone;
                    end else begin
                        rnd_d   = rnd_q + 6'd1;
                        state_d = (rnd_q < 6'd15) ? StFetch : StE1;
                    end
                end
            end
            StFetch: begin
                comp_wt_d = wbuf_q[j];
                state_d   = StWaitRise;
            end
            StE1: begin
                acc_d   = sum;
                state_d = StE2;
            end
            StE2: begin
                acc_d   = sum;
                state_d = StE3;
            end
            StE3: begin
                acc_d   = sum;
                state_d = StE4;
            end
            StE4: begin
                wr_en     = 1'b1;
                wr_idx    = j;
                wr_data   = sum;
                comp_wt_d = sum;
                state_d   = StWaitRise;
            end
            StWaitDone: begin
                if (comp_done) begin
                    digest_d = comp_digest;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rnd_q        <= 6'd0;
            acc_q        <= 32'd0;
            comp_wt_q    <= 32'd0;
            comp_start_q <= 1'b0;
            digest_q     <= 256'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stn_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            acc_q        <= acc_d;
            comp_wt_q    <= comp_wt_d;
            comp_start_q <= comp_start_d;
            digest_q     <= digest_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stn_q        <= comp_stn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) wbuf_q[i] <= 32'd0;
        end else if (wr_en) begin
            wbuf_q[wr_idx] <= wr_data;
        end
    end

    assign comp_start = comp_start_q;
    assign comp_wt    = comp_wt_q;
    assign digest_out = digest_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef SHA256_ROUND_CTRL_ERR_EN
    logic err_q;
    logic err_evt;

    always_comb begin
        err_evt = 1'b0;
        if (rise && (state_q inside {StFetch, StE1, StE2, StE3, StE4, StWaitDone})) begin
            err_evt = 1'b1;
        end
        if (comp_done && (state_q != StWaitDone)) begin
            err_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a behavioural SHA-256 core drives comp_stn/comp_done and a
// scoreboard monitor checks comp_wt at consume cycles and digest_out on every done.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_wr_en = 1'b0;
    logic [3:0]   blk_wr_addr = 4'd0;
    logic [31:0]  blk_wr_data = 32'd0;
    logic         go = 1'b0;
    logic         comp_start;
    logic [31:0]  comp_wt;
    logic         comp_stn = 1'b0;
    logic         comp_done = 1'b0;
    logic [255:0] comp_digest = 256'd0;
    logic [255:0] digest_out;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blk_wr_en   (blk_wr_en),
        .blk_wr_addr (blk_wr_addr),
        .blk_wr_data (blk_wr_data),
        .go          (go),
        .comp_start  (comp_start),
        .comp_wt     (comp_wt),
        .comp_stn    (comp_stn),
        .comp_done   (comp_done),
        .comp_digest (comp_digest),
        .digest_out  (digest_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

`ifdef SHA256_ROUND_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    localparam logic [255:0] ABC_DIGEST = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c,
        32'hb00361a3, 32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

    logic [31:0] abc_blk [16] = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};

    logic [31:0] h_init [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef struct {
        int          rnd;
        logic [31:0] val;
    } wt_exp_t;

    wt_exp_t      wt_q [$];
    logic [255:0] dig_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int mon_round = -1;
    logic mon_stn_q = 1'b0;

    logic        glitch_en = 1'b0;
    logic        core_on = 1'b0;
    int          core_cnt = 0;
    logic [31:0] hv [8];
    logic [31:0] wv [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " comp_start"}, comp_start, 0);
        check({tag, " comp_wt"}, comp_wt, 0);
        check({tag, " digest_out"}, digest_out, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic sha_round(input int t, input logic [31:0] w);
        logic [31:0] t1, t2, s0, s1, ch, mj;
        s1 = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
        ch = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
        t1 = wv[7] + s1 + ch + k_tab[t] + w;
        s0 = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
        mj = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
        t2 = s0 + mj;
        wv[7] = wv[6];
        wv[6] = wv[5];
        wv[5] = wv[4];
        wv[4] = wv[3] + t1;
        wv[3] = wv[2];
        wv[2] = wv[1];
        wv[1] = wv[0];
        wv[0] = t1 + t2;
    endtask

    // Core model: W_t consumed in cycle 6+8t after comp_start, stn high 4 cycles per round.
    initial begin
        int ph, t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                core_on   = 1'b0;
                comp_stn  = 1'b0;
                comp_done = 1'b0;
            end else begin
                comp_done = 1'b0;
                if (comp_start) begin
                    core_on  = 1'b1;
                    core_cnt = 0;
                    comp_stn = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        hv[i] = h_init[i];
                        wv[i] = h_init[i];
                    end
                end else if (core_on) begin
                    core_cnt++;
                    if (core_cnt >= 5 && core_cnt < 517) begin
                        ph = (core_cnt - 5) % 8;
                        t  = (core_cnt - 5) / 8;
                        if (ph == 0) sha_round(t, comp_wt);
                        comp_stn = (ph < 4);
                        if (glitch_en && t == 16 && ph == 1) comp_stn = 1'b0;
                    end else begin
                        comp_stn = 1'b0;
                    end
                    if (core_cnt == 519) begin
                        for (int i = 0; i < 8; i++) hv[i] = hv[i] + wv[i];
                        comp_digest = {hv[7], hv[6], hv[5], hv[4], hv[3], hv[2], hv[1], hv[0]};
                        comp_done   = 1'b1;
                        core_on     = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops expected comp_wt on stn rises and expected digests on done.
    initial begin
        wt_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                mon_round = -1;
                mon_stn_q = 1'b0;
            end else begin
                if (comp_start) mon_round = -1;
                if (comp_stn && !mon_stn_q) begin
                    mon_round++;
                    if (wt_q.size() > 0 && wt_q[0].rnd == mon_round) begin
                        e = wt_q.pop_front();
                        check($sformatf("comp_wt round %0d", e.rnd), comp_wt, e.val);
                    end
                end
                mon_stn_q = comp_stn;
                if (done) begin
                    n_done++;
                    if (dig_q.size() > 0) begin
                        check("digest_out", digest_out, dig_q.pop_front());
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected done: got done=1 required no done pulse");
                    end
                end
            end
        end
    end

    task automatic load_block();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            blk_wr_en   = 1'b1;
            blk_wr_addr = 4'(i);
            blk_wr_data = abc_blk[i];
        end
        @(negedge clk);
        blk_wr_en = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #3;
        check("cycle1 comp_start", comp_start, 1);
        check("cycle1 comp_wt", comp_wt, 32'h61626380);
        check("cycle1 busy", busy, 1);
    endtask

    task automatic wait_round(input int r);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            #3;
            if (mon_round >= r) break;
        end
        if (n == 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_round %0d: got timeout required round reached", r);
        end
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            #3;
            if (done) break;
        end
        if (n == 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: got timeout required done pulse");
        end else begin
            check("busy in done cycle", busy, 1);
            @(negedge clk);
            #3;
            check("done one cycle", done, 0);
            check("busy after done", busy, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check_zero("post-reset");

        // Run 1: plain "abc" with schedule-word checks.
        load_block();
        wt_q.push_back('{rnd: 0, val: 32'h61626380});
        wt_q.push_back('{rnd: 15, val: 32'h00000018});
        wt_q.push_back('{rnd: 16, val: 32'h61626380});
        wt_q.push_back('{rnd: 17, val: 32'h000F0000});
        dig_q.push_back(ABC_DIGEST);
        start_run();
        wait_done();

        // Run 2: go and block writes while busy must be ignored.
        load_block();
        dig_q.push_back(ABC_DIGEST);
        start_run();
        wait_round(20);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            go          = 1'b1;
            blk_wr_en   = 1'b1;
            blk_wr_addr = 4'(5 + k);
            blk_wr_data = 32'hDEADBEEF;
        end
        @(negedge clk);
        go        = 1'b0;
        blk_wr_en = 1'b0;
        #3;
        check("go while busy comp_start", comp_start, 0);
        check("go while busy busy", busy, 1);
        wait_done();
        check("err after clean runs", err, 0);

        // Run 3: reset at round 30, then reload and rerun.
        load_block();
        start_run();
        wait_round(30);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        check_zero("mid-run reset");
        @(negedge clk);
        rst_n = 1'b1;
        load_block();
        dig_q.push_back(ABC_DIGEST);
        start_run();
        wait_done();

        // Run 4: extra stn rise during E2.
        load_block();
        glitch_en = 1'b1;
        dig_q.push_back(ABC_DIGEST);
        start_run();
        check("err before glitch", err, 0);
        wait_round(17);
        @(negedge clk);
        #3;
        check("err after glitch", err, ERR_EXP);
        wait_done();
        glitch_en = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("err sticky", err, ERR_EXP);

        // Run 5: word-0 write coinciding with go.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("err cleared by reset", err, 0);
        load_block();
        @(negedge clk);
        go          = 1'b1;
        blk_wr_en   = 1'b1;
        blk_wr_addr = 4'd0;
        blk_wr_data = 32'hFFFFFFFF;
        @(negedge clk);
        go        = 1'b0;
        blk_wr_en = 1'b0;
        #3;
        check("go+write comp_start", comp_start, 1);
        check("go+write comp_wt", comp_wt, 32'hFFFFFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("digest queue drained", dig_q.size(), 0);
        check("wt queue drained", wt_q.size(), 0);
        check("done pulse count", n_done, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
